// File: rtl/hbridge_deadtime_gate.sv
// Full-bridge gate driver: turns the PWM pulse code into four gate commands,
// inserting a programmable dead time per leg and latching a fault on the illegal code.
module hbridge_deadtime_gate #(
    parameter int DT_W = 8
) (
    input  logic            clk100MHz,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      pwm_drive,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault_clr,
    output logic [3:0]      gate,
    output logic            fault,
    output logic            dt_active
);

    localparam logic [1:0] LEG_LOW  = 2'd0;
    localparam logic [1:0] LEG_DT   = 2'd1;
    localparam logic [1:0] LEG_HIGH = 2'd2;

    localparam logic [DT_W-1:0] CNT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

    logic [1:0]      pd_q;
    logic [1:0]      leg_state   [2];
    logic [DT_W-1:0] dt_cnt      [2];
    logic [1:0]      leg_state_n [2];
    logic [DT_W-1:0] dt_cnt_n    [2];
    logic [DT_W-1:0] dt_load;
    logic [1:0]      demand;
    logic            hold_off;
    logic            fault_n;
    logic [3:0]      gate_n;
    logic            dt_active_n;

    // A programmed dead time of zero would allow a hard hi/lo handover, so it is stretched to one cycle.
    always_comb begin
        dt_load = (dead_time == '0) ? CNT_ONE : dead_time;
    end

    // Leg A follows the positive code, leg B the negative code; anything else parks the leg low.
    always_comb begin
        demand[0] = (pd_q == 2'b10);
        demand[1] = (pd_q == 2'b01);
        hold_off  = !en || fault || (pd_q == 2'b11);

        for (int i = 0; i < 2; i++) begin
            leg_state_n[i] = leg_state[i];
            dt_cnt_n[i]    = dt_cnt[i];
            if (hold_off) begin
                leg_state_n[i] = LEG_DT;
                dt_cnt_n[i]    = dt_load;
            end else begin
                case (leg_state[i])
                    LEG_LOW: begin
                        if (demand[i]) begin
                            leg_state_n[i] = LEG_DT;
                            dt_cnt_n[i]    = dt_load;
                        end
                    end
                    LEG_HIGH: begin
                        if (!demand[i]) begin
                            leg_state_n[i] = LEG_DT;
                            dt_cnt_n[i]    = dt_load;
                        end
                    end
                    LEG_DT: begin
                        // The count is never restarted by a reversing demand; the leg resolves
                        // to whatever is demanded when the count expires.
                        if (dt_cnt[i] <= CNT_ONE) begin
                            leg_state_n[i] = demand[i] ? LEG_HIGH : LEG_LOW;
                        end else begin
                            dt_cnt_n[i] = dt_cnt[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        leg_state_n[i] = LEG_DT;
                        dt_cnt_n[i]    = dt_load;
                    end
                endcase
            end
        end

        gate_n = {leg_state_n[1] == LEG_LOW, leg_state_n[1] == LEG_HIGH,
                  leg_state_n[0] == LEG_LOW, leg_state_n[0] == LEG_HIGH};
        dt_active_n = (leg_state_n[0] == LEG_DT) || (leg_state_n[1] == LEG_DT);
    end

    // Setting the fault wins over clearing it, so a clear held during an illegal code has no effect.
    always_comb begin
        fault_n = fault;
        if (pd_q == 2'b11) begin
            fault_n = 1'b1;
        end else if (fault_clr) begin
            fault_n = 1'b0;
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            pd_q         <= 2'b00;
            fault        <= 1'b0;
            gate         <= 4'b0000;
            dt_active    <= 1'b1;
            leg_state[0] <= LEG_DT;
            leg_state[1] <= LEG_DT;
            dt_cnt[0]    <= dt_load;
            dt_cnt[1]    <= dt_load;
        end else begin
            pd_q         <= pwm_drive;
            fault        <= fault_n;
            gate         <= gate_n;
            dt_active    <= dt_active_n;
            leg_state[0] <= leg_state_n[0];
            leg_state[1] <= leg_state_n[1];
            dt_cnt[0]    <= dt_cnt_n[0];
            dt_cnt[1]    <= dt_cnt_n[1];
        end
    end

endmodule

// File: tb/tb_hbridge_deadtime_gate.sv
// Directed bench for hbridge_deadtime_gate: hand-computed gate/fault/dt_active
// sequences after each rising edge, plus a continuous hi/lo overlap check.
module tb_hbridge_deadtime_gate;

    localparam int DT_W = 8;

    logic            clk100MHz = 1'b0;
    logic            rst;
    logic            en;
    logic [1:0]      pwm_drive;
    logic [DT_W-1:0] dead_time;
    logic            fault_clr;
    logic [3:0]      gate;
    logic            fault;
    logic            dt_active;

    int checks   = 0;
    int failures = 0;
    bit overlap_on = 1'b0;

    hbridge_deadtime_gate #(.DT_W(DT_W)) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .en        (en),
        .pwm_drive (pwm_drive),
        .dead_time (dead_time),
        .fault_clr (fault_clr),
        .gate      (gate),
        .fault     (fault),
        .dt_active (dt_active)
    );

    always #5 clk100MHz = ~clk100MHz;

    // Shoot-through watchdog, sampled on the inactive edge.
    always @(negedge clk100MHz) begin
        if (overlap_on) begin
            checks++;
            assert (((gate[0] & gate[1]) | (gate[2] & gate[3])) === 1'b0) else begin
                failures++;
                $error("FAIL overlap observed gate=%b required no hi/lo pair", gate);
            end
        end
    end

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then compare all outputs 1 ns later.
    task automatic apply_stimulus(input string tag, input logic [3:0] g_exp, input logic dt_exp, input logic f_exp);
        @(posedge clk100MHz);
        #1;
        check_output({tag, "_gate"}, {4'b0, gate}, {4'b0, g_exp});
        check_output({tag, "_dt"}, {7'b0, dt_active}, {7'b0, dt_exp});
        check_output({tag, "_fault"}, {7'b0, fault}, {7'b0, f_exp});
    endtask

    task automatic apply_n(input int n, input string tag, input logic [3:0] g_exp, input logic dt_exp, input logic f_exp);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(tag, g_exp, dt_exp, f_exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        pwm_drive = 2'b00;
        dead_time = 8'd5;
        fault_clr = 1'b0;

        // Reset edge, then 5-cycle dead time before freewheel.
        apply_stimulus("reset", 4'b0000, 1'b1, 1'b0);
        overlap_on = 1'b1;
        rst = 1'b0;
        apply_n(4, "rel_dt", 4'b0000, 1'b1, 1'b0);
        apply_stimulus("rel_low", 4'b1010, 1'b0, 1'b0);
        apply_stimulus("rel_hold", 4'b1010, 1'b0, 1'b0);

        // 00 -> 10: leg A leaves LOW two edges after the change, B stays LOW.
        pwm_drive = 2'b10;
        apply_stimulus("pos_k", 4'b1010, 1'b0, 1'b0);
        apply_n(5, "pos_dt", 4'b1000, 1'b1, 1'b0);
        apply_stimulus("pos_on", 4'b1001, 1'b0, 1'b0);

        // 10 -> 00 mirrors back.
        pwm_drive = 2'b00;
        apply_stimulus("zero_k", 4'b1001, 1'b0, 1'b0);
        apply_n(5, "zero_dt", 4'b1000, 1'b1, 1'b0);
        apply_stimulus("zero_on", 4'b1010, 1'b0, 1'b0);

        // 10 -> 01 direct: both legs in dead time together.
        pwm_drive = 2'b10;
        apply_stimulus("p2_k", 4'b1010, 1'b0, 1'b0);
        apply_n(5, "p2_dt", 4'b1000, 1'b1, 1'b0);
        apply_stimulus("p2_on", 4'b1001, 1'b0, 1'b0);
        pwm_drive = 2'b01;
        apply_stimulus("neg_k", 4'b1001, 1'b0, 1'b0);
        apply_n(5, "neg_dt", 4'b0000, 1'b1, 1'b0);
        apply_stimulus("neg_on", 4'b0110, 1'b0, 1'b0);
        pwm_drive = 2'b00;
        apply_stimulus("n0_k", 4'b0110, 1'b0, 1'b0);
        apply_n(5, "n0_dt", 4'b0010, 1'b1, 1'b0);
        apply_stimulus("n0_on", 4'b1010, 1'b0, 1'b0);

        // Mid-DT reversal with dead_time=8; a dead_time change mid-DT is ignored.
        dead_time = 8'd8;
        pwm_drive = 2'b10;
        apply_stimulus("rev_k", 4'b1010, 1'b0, 1'b0);
        apply_n(3, "rev_dt_a", 4'b1000, 1'b1, 1'b0);
        pwm_drive = 2'b00;
        dead_time = 8'd3;
        apply_n(5, "rev_dt_b", 4'b1000, 1'b1, 1'b0);
        apply_stimulus("rev_low", 4'b1010, 1'b0, 1'b0);
        dead_time = 8'd5;

        // One-cycle illegal code latches the fault.
        pwm_drive = 2'b11;
        apply_stimulus("flt_k", 4'b1010, 1'b0, 1'b0);
        pwm_drive = 2'b00;
        apply_stimulus("flt_set", 4'b0000, 1'b1, 1'b1);
        apply_stimulus("flt_hold", 4'b0000, 1'b1, 1'b1);
        // Clear requested while the illegal code is present: set wins.
        pwm_drive = 2'b11;
        apply_stimulus("flt_11", 4'b0000, 1'b1, 1'b1);
        fault_clr = 1'b1;
        apply_n(2, "flt_clr11", 4'b0000, 1'b1, 1'b1);
        pwm_drive = 2'b00;
        apply_stimulus("flt_c1", 4'b0000, 1'b1, 1'b1);
        apply_stimulus("flt_clr", 4'b0000, 1'b1, 1'b0);
        fault_clr = 1'b0;
        apply_n(4, "flt_dt", 4'b0000, 1'b1, 1'b0);
        apply_stimulus("flt_on", 4'b1010, 1'b0, 1'b0);

        // One-cycle pulse with dead_time=2 still runs the full dead time.
        dead_time = 8'd2;
        pwm_drive = 2'b10;
        apply_stimulus("pls_k", 4'b1010, 1'b0, 1'b0);
        pwm_drive = 2'b00;
        apply_n(2, "pls_dt", 4'b1000, 1'b1, 1'b0);
        apply_stimulus("pls_low", 4'b1010, 1'b0, 1'b0);

        // dead_time=0 acts as one cycle; en drop and raise.
        dead_time = 8'd0;
        pwm_drive = 2'b10;
        apply_stimulus("dt0_k", 4'b1010, 1'b0, 1'b0);
        apply_stimulus("dt0_dt", 4'b1000, 1'b1, 1'b0);
        apply_stimulus("dt0_on", 4'b1001, 1'b0, 1'b0);
        en = 1'b0;
        apply_n(2, "en_off", 4'b0000, 1'b1, 1'b0);
        en = 1'b1;
        apply_stimulus("en_on", 4'b1001, 1'b0, 1'b0);

        // Reset mid-operation with the fault latched.
        dead_time = 8'd5;
        pwm_drive = 2'b11;
        apply_stimulus("rst_k", 4'b1001, 1'b0, 1'b0);
        apply_stimulus("rst_flt", 4'b0000, 1'b1, 1'b1);
        rst = 1'b1;
        pwm_drive = 2'b00;
        apply_stimulus("rst_mid", 4'b0000, 1'b1, 1'b0);
        rst = 1'b0;
        apply_n(4, "rst_dt", 4'b0000, 1'b1, 1'b0);
        apply_stimulus("rst_low", 4'b1010, 1'b0, 1'b0);

        overlap_on = 1'b0;
        @(negedge clk100MHz);
        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
